// File: rtl/id_ex_register_if.sv
// ID->EX bundle: decoded control, operands and addresses in; registered copies, valid and event counters out.
// The slave modport is the pipeline register; the master modport is the ID stage that drives it.
interface id_ex_register_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);
  logic              stall_i;
  logic              flush_i;
  logic              nop_i;
  logic [1:0]        ALUOp_i;
  logic              ALUSrc_i;
  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic              MemRead_i;
  logic              MemWrite_i;
  logic [DATA_W-1:0] RS1data_i;
  logic [DATA_W-1:0] RS2data_i;
  logic [DATA_W-1:0] Imm_i;
  logic [9:0]        Funct_i;
  logic [4:0]        RS1addr_i;
  logic [4:0]        RS2addr_i;
  logic [4:0]        RDaddr_i;

  logic [1:0]        ALUOp_o;
  logic              ALUSrc_o;
  logic              RegWrite_o;
  logic              MemtoReg_o;
  logic              MemRead_o;
  logic              MemWrite_o;
  logic [DATA_W-1:0] RS1data_o;
  logic [DATA_W-1:0] RS2data_o;
  logic [DATA_W-1:0] Imm_o;
  logic [9:0]        Funct_o;
  logic [4:0]        RS1addr_o;
  logic [4:0]        RS2addr_o;
  logic [4:0]        RDaddr_o;
  logic              valid_o;
  logic [CNT_W-1:0]  bubble_cnt_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  inst_cnt_o;

  modport slave (
    input  stall_i, flush_i, nop_i,
    input  ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
    input  RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    output ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
    output RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
    output valid_o, bubble_cnt_o, stall_cnt_o, inst_cnt_o
  );

  modport master (
    output stall_i, flush_i, nop_i,
    output ALUOp_i, ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i,
    output RS1data_i, RS2data_i, Imm_i, Funct_i, RS1addr_i, RS2addr_i, RDaddr_i,
    input  ALUOp_o, ALUSrc_o, RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o,
    input  RS1data_o, RS2data_o, Imm_o, Funct_o, RS1addr_o, RS2addr_o, RDaddr_o,
    input  valid_o, bubble_cnt_o, stall_cnt_o, inst_cnt_o
  );
endinterface

// File: rtl/id_ex_register.sv
// ID/EX pipeline register, 1-cycle latency, all outputs registered; priority flush > stall > nop > load.
// Backpressure: stall_i holds every register (valid included) indefinitely; flush/nop load an all-zero bubble.
module id_ex_register #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  id_ex_register_if.slave io
);

  typedef struct packed {
    logic [1:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              memto_reg;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [9:0]        funct;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
  } payload_t;

  payload_t         w_in;
  payload_t         r_pay;
  logic             r_valid;
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_inst_cnt;
  logic             w_bubble;
  logic             w_hold;

  assign w_in = {io.ALUOp_i, io.ALUSrc_i, io.RegWrite_i, io.MemtoReg_i, io.MemRead_i,
                 io.MemWrite_i, io.RS1data_i, io.RS2data_i, io.Imm_i, io.Funct_i,
                 io.RS1addr_i, io.RS2addr_i, io.RDaddr_i};

  // Flush overrides stall; a stall masks a pending load-use nop.
  assign w_bubble = io.flush_i | (io.nop_i & ~io.stall_i);
  assign w_hold   = io.stall_i & ~io.flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pay        <= '0;
      r_valid      <= 1'b0;
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
      r_inst_cnt   <= '0;
    end else if (w_bubble) begin
      r_pay   <= '0;
      r_valid <= 1'b0;
      if (r_bubble_cnt != {CNT_W{1'b1}}) r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
    end else if (w_hold) begin
      if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_pay   <= w_in;
      r_valid <= 1'b1;
      if (r_inst_cnt != {CNT_W{1'b1}}) r_inst_cnt <= r_inst_cnt + CNT_W'(1);
    end
  end

  assign io.ALUOp_o      = r_pay.alu_op;
  assign io.ALUSrc_o     = r_pay.alu_src;
  assign io.RegWrite_o   = r_pay.reg_write;
  assign io.MemtoReg_o   = r_pay.memto_reg;
  assign io.MemRead_o    = r_pay.mem_read;
  assign io.MemWrite_o   = r_pay.mem_write;
  assign io.RS1data_o    = r_pay.rs1_data;
  assign io.RS2data_o    = r_pay.rs2_data;
  assign io.Imm_o        = r_pay.imm;
  assign io.Funct_o      = r_pay.funct;
  assign io.RS1addr_o    = r_pay.rs1_addr;
  assign io.RS2addr_o    = r_pay.rs2_addr;
  assign io.RDaddr_o     = r_pay.rd_addr;
  assign io.valid_o      = r_valid;
  assign io.bubble_cnt_o = r_bubble_cnt;
  assign io.stall_cnt_o  = r_stall_cnt;
  assign io.inst_cnt_o   = r_inst_cnt;

endmodule

// File: tb/tb_id_ex_register.sv
// Scoreboard bench for id_ex_register: the driver pushes the expected post-edge view, a monitor pops and compares.
// Counters are narrowed to 4 bits so saturation is reachable.
module tb_id_ex_register;
  localparam int DW  = 32;
  localparam int CNT = 4;
  localparam int CNT_MAX = (1 << CNT) - 1;

  typedef struct packed {
    logic        stall, flush, nop;
    logic [1:0]  alu;
    logic        src, rw, m2r, mr, mw;
    logic [31:0] rs1, rs2, imm;
    logic [9:0]  funct;
    logic [4:0]  a1, a2, rd;
  } in_t;

  typedef struct packed {
    logic [1:0]     alu;
    logic           src, rw, m2r, mr, mw;
    logic [31:0]    rs1, rs2, imm;
    logic [9:0]     funct;
    logic [4:0]     a1, a2, rd;
    logic           valid;
    logic [CNT-1:0] bub, stl, ins;
  } out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_register_if #(.DATA_W(DW), .CNT_W(CNT)) bus ();
  id_ex_register #(.DATA_W(DW), .CNT_W(CNT)) dut (.clk_i(clk), .rst_i(rst), .io(bus));

  out_t  expq[$];
  string tagq[$];
  int    total = 0;
  int    bad   = 0;

  // Reference: what EX should see, plus plain integer event tallies.
  out_t m_slot;
  int   n_bub, n_stl, n_ins;

  function automatic int sat(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic model_reset();
    m_slot = '0;
    n_bub = 0; n_stl = 0; n_ins = 0;
  endtask

  task automatic push(input string tag);
    out_t e;
    e = m_slot;
    e.bub = CNT'(n_bub);
    e.stl = CNT'(n_stl);
    e.ins = CNT'(n_ins);
    expq.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic model_edge(input in_t x, input string tag);
    if (x.flush || (x.nop && !x.stall)) begin
      m_slot = '0;
      n_bub = sat(n_bub);
    end else if (x.stall) begin
      n_stl = sat(n_stl);
    end else begin
      m_slot = '0;
      m_slot.alu = x.alu; m_slot.src = x.src; m_slot.rw = x.rw; m_slot.m2r = x.m2r;
      m_slot.mr = x.mr;   m_slot.mw = x.mw;   m_slot.rs1 = x.rs1; m_slot.rs2 = x.rs2;
      m_slot.imm = x.imm; m_slot.funct = x.funct; m_slot.a1 = x.a1; m_slot.a2 = x.a2;
      m_slot.rd = x.rd;   m_slot.valid = 1'b1;
      n_ins = sat(n_ins);
    end
    push(tag);
  endtask

  task automatic drive(input in_t x);
    bus.stall_i = x.stall;   bus.flush_i = x.flush;   bus.nop_i = x.nop;
    bus.ALUOp_i = x.alu;     bus.ALUSrc_i = x.src;    bus.RegWrite_i = x.rw;
    bus.MemtoReg_i = x.m2r;  bus.MemRead_i = x.mr;    bus.MemWrite_i = x.mw;
    bus.RS1data_i = x.rs1;   bus.RS2data_i = x.rs2;   bus.Imm_i = x.imm;
    bus.Funct_i = x.funct;   bus.RS1addr_i = x.a1;    bus.RS2addr_i = x.a2;
    bus.RDaddr_i = x.rd;
  endtask

  function automatic in_t rand_in(input int p_stall, input int p_flush, input int p_nop);
    in_t x;
    x = {$urandom, $urandom, $urandom, $urandom, $urandom};
    x.stall = ($urandom_range(0, 99) < p_stall);
    x.flush = ($urandom_range(0, 99) < p_flush);
    x.nop   = ($urandom_range(0, 99) < p_nop);
    return x;
  endfunction

  function automatic in_t instr(input logic [1:0] alu, input logic src, input logic rw,
                                input logic m2r, input logic mr, input logic mw,
                                input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] imm, input logic [9:0] funct,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd);
    in_t x;
    x = '0;
    x.alu = alu; x.src = src; x.rw = rw; x.m2r = m2r; x.mr = mr; x.mw = mw;
    x.rs1 = rs1; x.rs2 = rs2; x.imm = imm; x.funct = funct; x.a1 = a1; x.a2 = a2; x.rd = rd;
    return x;
  endfunction

  task automatic step(input in_t x, input string tag);
    @(negedge clk);
    drive(x);
    model_edge(x, tag);
  endtask

  // Reset pulse lands between edges; the following edge then applies x normally.
  task automatic pulse_rst(input in_t x, input string tag);
    @(negedge clk);
    drive(x);
    #2 rst = 1'b1;
    model_reset();
    push({tag, "_async"});
    #2 rst = 1'b0;
    model_edge(x, {tag, "_after"});
  endtask

  initial forever begin
    out_t got, e;
    string t;
    @(posedge clk or posedge rst);
    #1;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      t = tagq.pop_front();
      got = {bus.ALUOp_o, bus.ALUSrc_o, bus.RegWrite_o, bus.MemtoReg_o, bus.MemRead_o,
             bus.MemWrite_o, bus.RS1data_o, bus.RS2data_o, bus.Imm_o, bus.Funct_o,
             bus.RS1addr_o, bus.RS2addr_o, bus.RDaddr_o, bus.valid_o,
             bus.bubble_cnt_o, bus.stall_cnt_o, bus.inst_cnt_o};
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL %s: got=%h want=%h (valid %b/%b bub %0d/%0d stl %0d/%0d ins %0d/%0d)",
                 t, got, e, got.valid, e.valid, got.bub, e.bub, got.stl, e.stl, got.ins, e.ins);
      end
    end
  end

  initial begin
    in_t x, lw, rt, add;
    int guard;
    model_reset();
    drive(rand_in(0, 0, 0));

    // Reset held across an edge with nonzero inputs.
    @(negedge clk);
    drive(rand_in(50, 50, 50));
    push("reset_hold");
    @(negedge clk);
    rst = 1'b0;
    x = instr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1, 32'h2, 32'h0, 10'h0, 5'd1, 5'd2, 5'd5);
    drive(x);
    model_edge(x, "first_after_release");

    step(rand_in(0, 0, 0), "load_rand");
    x = rand_in(0, 0, 0);
    x.rw = 1'b1; x.rd = 5'd5;
    pulse_rst(x, "rst_pulse");

    lw = instr(2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 32'h10, 10'h002, 5'd3, 5'd0, 5'd7);
    step(lw, "lw_pass");

    rt = instr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'hAAAA, 32'h5555, 32'h0, 10'h100, 5'd7, 5'd8, 5'd9);
    x = rt; x.nop = 1'b1;
    step(x, "loaduse_bubble");
    step(rt, "rtype_after_bubble");

    add = instr(2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h11, 32'h22, 32'h0, 10'h000, 5'd4, 5'd6, 5'd10);
    step(add, "add_load");
    for (int i = 0; i < 3; i++) step(rand_in(100, 0, 0), "stall_hold");
    x = rand_in(100, 100, 0);
    step(x, "stall_flush");
    step(add, "add_reload");
    x = rand_in(100, 0, 100); x.flush = 1'b0;
    step(x, "stall_masks_nop");
    x = rand_in(0, 100, 100); x.stall = 1'b0;
    step(x, "flush_nop_once");

    x = rand_in(0, 0, 100); x.stall = 1'b0; x.flush = 1'b0;
    for (int i = 0; i < 20; i++) step(x, "bubble_saturate");
    for (int i = 0; i < 20; i++) step(rand_in(100, 0, 0), "stall_saturate");
    for (int i = 0; i < 20; i++) step(rand_in(0, 0, 0), "inst_saturate");

    for (int i = 0; i < 600; i++) begin
      x = rand_in(30, 10, 20);
      if ($urandom_range(0, 99) < 4) pulse_rst(x, "rand_rst");
      else step(x, "random");
    end

    guard = 0;
    while (expq.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (expq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: pending=%0d required=0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_register.md
# id_ex_register

ID/EX pipeline register of the five-stage RISC-V core. It captures the decoded control bundle from the control unit, plus register-file operands, immediate, funct bits and register addresses from ID, and presents them to EX one cycle later. It implements hold (stall), bubble insertion (hazard NoOp and branch flush), a valid bit for EX/forwarding qualification, and saturating event counters for performance debug.

## Interface
- DATA_W, 32, width of operand, immediate and data fields
- CNT_W, 32, width of each event counter
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous, active-high
- stall_i  in  1  hold current contents (downstream stall)
- flush_i  in  1  load bubble (branch taken in ID)
- nop_i  in  1  load bubble (load-use hazard, same as control unit's NoOp)
- ALUOp_i / ALUOp_o  in/out  2  ALU operation class
- ALUSrc_i, RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i  in  1 each  control bits; matching *_o outputs, 1 each
- RS1data_i / RS1data_o, RS2data_i / RS2data_o  in/out  DATA_W  register operands
- Imm_i / Imm_o  in/out  DATA_W  sign-extended immediate
- Funct_i / Funct_o  in/out  10  {funct7, funct3}
- RS1addr_i / RS1addr_o, RS2addr_i / RS2addr_o, RDaddr_i / RDaddr_o  in/out  5  register addresses
- valid_o  out  1  EX slot holds a real instruction
- bubble_cnt_o  out  CNT_W  bubbles loaded
- stall_cnt_o  out  CNT_W  stall cycles
- inst_cnt_o  out  CNT_W  valid instructions loaded

## Operation
- Three per-edge actions, priority: flush_i > stall_i > nop_i > load.
- flush_i=1: load bubble regardless of stall_i/nop_i.
- stall_i=1, flush_i=0: every register, including valid_o, keeps its value; nop_i ignored.
- nop_i=1, stall_i=0, flush_i=0: load bubble.
- Otherwise load: every *_o takes its *_i; valid_o <= 1.
- Bubble: all control outputs 0 (ALUOp_o=00, ALUSrc_o=RegWrite_o=MemtoReg_o=MemRead_o=MemWrite_o=0), all data/address/funct fields 0, valid_o=0. A bubble must never write the register file or memory.
- Counters, all saturating at 2^CNT_W-1 (no wrap):
  - bubble_cnt_o +1 on each edge a bubble is loaded (flush or nop path).
  - stall_cnt_o +1 on each edge stall_i=1 and flush_i=0.
  - inst_cnt_o +1 on each normal load edge.
  - At most one counter increments per edge.
- Counters reset only by rst_i.

## Timing
- Latency 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- All outputs are registers; no combinational input-to-output path.
- rst_i assertion: all outputs go to 0 immediately (asynchronously), including valid_o and counters; held while rst_i=1.
- rst_i deassertion: first rising edge with rst_i=0 applies normal priority; no extra wait cycle.
- Reset mid-stall or mid-flush: reset wins; no pending stall/flush state survives.
- Stall is unbounded: contents held for any number of consecutive cycles; stall_cnt_o increments each of them.
- flush_i and nop_i together: one bubble, bubble_cnt_o +1 only once.

## Test plan
- Reset: drive all inputs nonzero, pulse rst_i between clock edges -> all outputs 0 before next edge; first edge after release with RegWrite_i=1, RDaddr_i=5 -> RegWrite_o=1, RDaddr_o=5, valid_o=1, inst_cnt_o=1.
- Pass-through: lw (ALUOp=00, ALUSrc=1, MemRead=1, MemtoReg=1, RegWrite=1, Imm=0x10, RS1data=0x100) -> identical values on outputs one cycle later, valid_o=1.
- Load-use bubble: nop_i=1 for one edge with R-type inputs -> all control 0, valid_o=0, bubble_cnt_o=1; next edge nop_i=0 -> R-type values (ALUOp_o=10) appear.
- Stall vs flush: load add, then stall_i=1 for 3 edges with changing inputs -> outputs unchanged, stall_cnt_o=3; then stall_i=1 and flush_i=1 -> bubble, stall_cnt_o stays 3, bubble_cnt_o=1.
- Stall masks nop: stall_i=1 and nop_i=1 -> contents held, bubble_cnt_o unchanged, stall_cnt_o +1.
- Saturation: with CNT_W=4, apply 20 nop edges -> bubble_cnt_o stops at 15, no wrap to 0.
